wave_capture_mc: RTL and testbench
==================================

WAVE_CAPTURE_MC -- requirements
Module: wave_capture_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of captured channels (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 16, input sample width (signed two's complement).
REQ-003 SHALL have parameter OUT_W, default 8, stored sample width (OUT_W <= SAMPLE_W).
REQ-004 SHALL have parameter DEPTH_LOG2, default 8, log2 of samples stored per channel per buffer.
REQ-005 SHALL have parameter TO_W, default 12, auto-trigger timeout counter width.
REQ-006 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 Ports: reset  in  1  asynchronous, active-low reset.
REQ-008 Ports: new_sample  in  1  one-cycle strobe, sample bus valid.
REQ-009 Ports: sample  in  NUM_CH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W].
REQ-010 Ports: trig_ch  in  3  channel index used for triggering.
REQ-011 Ports: decim  in  4  keep one strobe in decim+1.
REQ-012 Ports: display_idle  in  1  high while the display is not reading (vertical blank).
REQ-013 Ports: rd_ch  in  3, rd_addr  in  DEPTH_LOG2  display read channel/address.
REQ-014 Ports: rd_data  out  OUT_W  stored sample; read_index  out  1  buffer currently shown.
REQ-015 Ports: busy  out  1  high in ACTIVE; forced  out  1  last capture started by timeout.

Function
REQ-016 Strobe qualifier: decimation counter increments on each new_sample; a strobe is accepted when counter == decim, after which the counter clears to 0. decim=0 accepts every strobe.
REQ-017 Stored value: top OUT_W bits of each channel sample with MSB inverted (offset binary); midscale 0 maps to 2^(OUT_W-1).
REQ-018 FSM states: ARMED, ACTIVE, WAIT_IDLE.
REQ-019 ARMED -> ACTIVE on the accepted sample where trig_ch was negative on the previous accepted sample and is >= 0 now (rising zero crossing); that sample is stored at address 0.
REQ-020 ARMED -> ACTIVE also when the timeout counter (counts accepted samples in ARMED) reaches 2^TO_W-1; forced is set to 1. forced is cleared on a real trigger.
REQ-021 ACTIVE: each accepted sample writes all NUM_CH channels to the write buffer (~read_index) at the current address, then the address increments; after address 2^DEPTH_LOG2-1 is written, -> WAIT_IDLE.
REQ-022 Per-channel writes complete within NUM_CH cycles of acceptance; a strobe arriving while writes are pending is dropped, and decim >= NUM_CH-1 at a 1-cycle strobe spacing is a usage restriction.
REQ-023 WAIT_IDLE: on the first cycle display_idle is high, read_index toggles and state -> ARMED; the timeout counter and previous-sign register clear.
REQ-024 read_index changes only in REQ-023; never while display_idle is low.
REQ-025 rd_data = buffer[read_index][rd_ch][rd_addr], registered, latency 1 cycle; rd_ch >= NUM_CH returns 0.
REQ-026 trig_ch >= NUM_CH selects channel 0.
REQ-027 Changing trig_ch or decim mid-capture does not abort ACTIVE; new values apply on the next accepted sample.

Reset
REQ-028 On reset low: state ARMED, read_index 0, busy 0, forced 0, rd_data 0, all counters and address 0, previous-sign register "non-negative".
REQ-029 Reset asserted mid-ACTIVE abandons the capture; RAM contents are not cleared.
REQ-030 Reset deassertion is synchronised internally to clk before use.

Structure
REQ-031 Shared package holds the FSM state encoding and the offset-binary conversion function.
REQ-032 Storage in one sub-module, sample_ram_2buf: one write port, one registered read port, address {buffer, channel, index}, depth 2*NUM_CH*2^DEPTH_LOG2, inferable block RAM.

Verification
REQ-033 NUM_CH=2, decim=0, ch0 sine crossing zero at strobe 40 -> busy rises then, 256 writes per channel, WAIT_IDLE; display_idle pulse -> read_index 0->1; rd_addr 0 reads 0x80 region.
REQ-034 ch0 constant -100 for 4096 strobes -> forced=1, capture starts on strobe 4095.
REQ-035 decim=3, 1024 strobes with trigger at strobe 0 -> exactly 256 samples stored, every 4th input.
REQ-036 display_idle held low after capture -> read_index unchanged, new strobes ignored; idle high -> swap within 1 cycle.
REQ-037 Reset pulse at address 100 in ACTIVE -> all outputs at reset values, next trigger restarts at address 0.
REQ-038 sample ch1 = 0x7FFF, 0x8000, 0x0000 -> stored 0xFF, 0x00, 0x80; rd_ch=5 -> rd_data 0.

Source files
------------

// File: rtl/wave_capture_mc_pkg.sv
// Shared definitions for the multi-channel waveform capture block:
// FSM state encoding and sample-to-offset-binary conversion.
package wave_capture_mc_pkg;

  typedef enum logic [1:0] {
    ST_ARMED     = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } cap_state_e;

  localparam int CONV_W = 64;

  // Keep the top out_w bits of a sample_w-bit two's complement value and
  // flip its MSB, so midscale 0 lands on 2^(out_w-1).
  function automatic logic [CONV_W-1:0] offset_binary(input logic [CONV_W-1:0] s,
                                                      input int sample_w,
                                                      input int out_w);
    logic [CONV_W-1:0] r;
    r = s >> (sample_w - out_w);
    r = r ^ (64'd1 << (out_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/wave_capture_mc_if.sv
// Sample input, display read and status signals of the capture block.
interface wave_capture_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = 8,
  parameter int DEPTH_LOG2 = 8
);
  logic                         new_sample;
  logic [NUM_CH*SAMPLE_W-1:0]   sample;
  logic [2:0]                   trig_ch;
  logic [3:0]                   decim;
  logic                         display_idle;
  logic [2:0]                   rd_ch;
  logic [DEPTH_LOG2-1:0]        rd_addr;
  logic [OUT_W-1:0]             rd_data;
  logic                         read_index;
  logic                         busy;
  logic                         forced;

  modport master (
    output new_sample, sample, trig_ch, decim, display_idle, rd_ch, rd_addr,
    input  rd_data, read_index, busy, forced
  );

  modport slave (
    input  new_sample, sample, trig_ch, decim, display_idle, rd_ch, rd_addr,
    output rd_data, read_index, busy, forced
  );
endinterface

// File: rtl/wave_capture_mc_sample_ram_2buf.sv
// Double-buffered sample store: one write port, one registered read port.
// The array itself is never reset so it maps onto block RAM.
module sample_ram_2buf #(
  parameter int OUT_W = 8,
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  output logic [OUT_W-1:0] rdata
);
  logic [OUT_W-1:0] mem [WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; a disabled read returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end
endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel waveform capture: decimate strobes, arm on a rising zero
// crossing (or timeout), fill the hidden buffer, swap during display blank.
module wave_capture_mc
  import wave_capture_mc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter int TO_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  wave_capture_mc_if.slave bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WORDS  = 2 * NUM_CH * DEPTH;
  localparam int RAM_AW = $clog2(WORDS);
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};
  localparam logic [TO_W-1:0]       TO_MAX    = {TO_W{1'b1}};
  localparam logic [2:0]            LAST_CH   = 3'(NUM_CH - 1);

  logic [1:0] rst_sync;
  logic rst_n;
  cap_state_e state, next_state;
  logic [3:0] dec_cnt;
  logic qual, pending, accept, trig_neg;
  logic start_cap, real_trig, swap, do_write;
  logic prev_neg, busy, forced, read_index;
  logic [TO_W-1:0] to_cnt;
  logic [DEPTH_LOG2-1:0] addr, wr_idx;
  logic wr_active, wr_buf;
  logic [2:0] wr_ch;
  logic [NUM_CH-1:0][OUT_W-1:0] hold;
  logic [OUT_W-1:0] wdata, rd_q;
  logic rd_ok;
  int wa_lin, ra_lin;

  // Reset asserts immediately, releases two clocks after reset goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  // A strobe is qualified once per decim+1; it is dropped if channel writes
  // of the previous sample would still be in flight next cycle.
  assign qual    = bus.new_sample && (dec_cnt == bus.decim);
  assign pending = wr_active && (wr_ch != LAST_CH);
  assign accept  = qual && !pending;

  // Decimation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= 4'd0;
    end else if (bus.new_sample) begin
      dec_cnt <= (dec_cnt == bus.decim) ? 4'd0 : dec_cnt + 4'd1;
    end else begin
      dec_cnt <= dec_cnt;
    end
  end

  // Sign of the trigger channel; out-of-range selections fall back to channel 0.
  always_comb begin
    trig_neg = bus.sample[SAMPLE_W-1];
    for (int c = 1; c < NUM_CH; c++) begin
      trig_neg = (int'(bus.trig_ch) == c) ? bus.sample[c*SAMPLE_W + SAMPLE_W - 1] : trig_neg;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARMED;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state and capture control strobes.
  always_comb begin
    next_state = state;
    start_cap  = 1'b0;
    real_trig  = 1'b0;
    swap       = 1'b0;
    case (state)
      ST_ARMED: begin
        if (accept && prev_neg && !trig_neg) begin
          next_state = ST_ACTIVE;
          start_cap  = 1'b1;
          real_trig  = 1'b1;
        end else if (accept && (to_cnt == TO_MAX)) begin
          next_state = ST_ACTIVE;
          start_cap  = 1'b1;
        end else begin
          next_state = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (accept && (addr == LAST_ADDR)) begin
          next_state = ST_WAIT_IDLE;
        end else begin
          next_state = ST_ACTIVE;
        end
      end
      ST_WAIT_IDLE: begin
        if (bus.display_idle) begin
          next_state = ST_ARMED;
          swap       = 1'b1;
        end else begin
          next_state = ST_WAIT_IDLE;
        end
      end
      default: next_state = ST_ARMED;
    endcase
  end

  assign do_write = start_cap || ((state == ST_ACTIVE) && accept);

  // Capture bookkeeping: timeout, previous sign, address, buffer swap, status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      prev_neg   <= 1'b0;
      addr       <= '0;
      forced     <= 1'b0;
      busy       <= 1'b0;
      read_index <= 1'b0;
    end else begin
      busy <= (next_state == ST_ACTIVE);
      if (swap) begin
        read_index <= ~read_index;
        to_cnt     <= '0;
        prev_neg   <= 1'b0;
      end else if ((state == ST_ARMED) && accept) begin
        prev_neg <= trig_neg;
        to_cnt   <= start_cap ? to_cnt : to_cnt + TO_W'(1);
      end else begin
        to_cnt <= to_cnt;
      end
      if (start_cap) begin
        forced <= !real_trig;
        addr   <= DEPTH_LOG2'(1);
      end else if (do_write) begin
        addr <= addr + DEPTH_LOG2'(1);
      end else begin
        addr <= addr;
      end
    end
  end

  // Latch converted samples, then write one channel per cycle. The target
  // buffer is latched too, so a swap cannot redirect the tail of a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_active <= 1'b0;
      wr_ch     <= 3'd0;
      wr_idx    <= '0;
      wr_buf    <= 1'b0;
      hold      <= '0;
    end else if (do_write) begin
      wr_active <= 1'b1;
      wr_ch     <= 3'd0;
      wr_idx    <= start_cap ? '0 : addr;
      wr_buf    <= ~read_index;
      for (int c = 0; c < NUM_CH; c++) begin
        hold[c] <= OUT_W'(offset_binary(64'(bus.sample[c*SAMPLE_W +: SAMPLE_W]), SAMPLE_W, OUT_W));
      end
    end else if (wr_active) begin
      if (wr_ch == LAST_CH) begin
        wr_active <= 1'b0;
      end else begin
        wr_ch <= wr_ch + 3'd1;
      end
    end else begin
      wr_active <= 1'b0;
    end
  end

  // RAM addressing: linear {buffer, channel, index}; write data channel mux.
  always_comb begin
    wdata = hold[0];
    for (int c = 1; c < NUM_CH; c++) begin
      wdata = (wr_ch == 3'(c)) ? hold[c] : wdata;
    end
    rd_ok  = int'(bus.rd_ch) < NUM_CH;
    wa_lin = (int'(wr_buf) * NUM_CH + int'(wr_ch)) * DEPTH + int'(wr_idx);
    ra_lin = (int'(read_index) * NUM_CH + (rd_ok ? int'(bus.rd_ch) : 0)) * DEPTH
             + int'(bus.rd_addr);
  end

  sample_ram_2buf #(
    .OUT_W (OUT_W),
    .WORDS (WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_active),
    .waddr (RAM_AW'(wa_lin)),
    .wdata (wdata),
    .rd_en (rd_ok),
    .raddr (RAM_AW'(ra_lin)),
    .rdata (rd_q)
  );

  assign bus.rd_data    = rd_q;
  assign bus.read_index = read_index;
  assign bus.busy       = busy;
  assign bus.forced     = forced;
endmodule

// File: tb/tb_wave_capture_mc.sv
// Directed self-checking bench for wave_capture_mc (default parameters).
module tb_wave_capture_mc;
  localparam int NUM_CH = 2, SAMPLE_W = 16, OUT_W = 8, DEPTH_LOG2 = 8, TO_W = 12;
  localparam logic [15:0] NEG100 = 16'hFF9C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  wave_capture_mc_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
                       .DEPTH_LOG2(DEPTH_LOG2)) bus_if ();

  wave_capture_mc #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
                    .DEPTH_LOG2(DEPTH_LOG2), .TO_W(TO_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] c0, input logic [15:0] c1);
    @(negedge clk);
    bus_if.sample     = {c1, c0};
    bus_if.new_sample = 1'b1;
    @(negedge clk);
    bus_if.new_sample = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] ch, input logic [7:0] a,
                          input logic [7:0] exp);
    @(negedge clk);
    bus_if.rd_ch   = ch;
    bus_if.rd_addr = a;
    @(negedge clk);
    check(tag, 32'(bus_if.rd_data), 32'(exp));
  endtask

  task automatic idle_swap(input string tag, input logic exp_ri);
    @(negedge clk);
    bus_if.display_idle = 1'b1;
    @(negedge clk);
    check(tag, 32'(bus_if.read_index), 32'(exp_ri));
    bus_if.display_idle = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus_if.new_sample   = 1'b0;
    bus_if.sample       = '0;
    bus_if.trig_ch      = 3'd0;
    bus_if.decim        = 4'd0;
    bus_if.display_idle = 1'b0;
    bus_if.rd_ch        = 3'd0;
    bus_if.rd_addr      = 8'd0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_forced", 32'(bus_if.forced), 32'd0);
    check("rst_read_index", 32'(bus_if.read_index), 32'd0);
    check("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
    release_reset();

    // Zero crossing on ch0 at strobe 40; ch1 carries conversion corner cases.
    for (int k = 0; k < 40; k++) strobe(16'(-(40 - k) * 16), 16'h0000);
    check("armed_before_cross", 32'(bus_if.busy), 32'd0);
    strobe(16'h0000, 16'h7FFF);
    check("busy_at_cross", 32'(bus_if.busy), 32'd1);
    strobe(16'h0040, 16'h8000);
    strobe(16'h0080, 16'h0000);
    for (int k = 43; k < 295; k++) strobe(16'((k - 40) * 64), 16'h1234);
    check("busy_before_last", 32'(bus_if.busy), 32'd1);
    strobe(16'((295 - 40) * 64), 16'h1234);
    check("busy_after_256", 32'(bus_if.busy), 32'd0);
    for (int k = 0; k < 3; k++) strobe(16'h0100, 16'h0100);
    repeat (5) @(negedge clk);
    check("wait_idle_no_swap", 32'(bus_if.read_index), 32'd0);
    check("wait_idle_ignores", 32'(bus_if.busy), 32'd0);
    idle_swap("swap_0_to_1", 1'b1);
    read_chk("ch0_a0", 3'd0, 8'd0, 8'h80);
    read_chk("ch0_a100", 3'd0, 8'd100, 8'h99);
    read_chk("ch0_a255", 3'd0, 8'd255, 8'hBF);
    read_chk("ch1_7fff", 3'd1, 8'd0, 8'hFF);
    read_chk("ch1_8000", 3'd1, 8'd1, 8'h00);
    read_chk("ch1_0000", 3'd1, 8'd2, 8'h80);
    read_chk("ch1_a255", 3'd1, 8'd255, 8'h92);
    read_chk("rd_ch5_zero", 3'd5, 8'd0, 8'h00);

    // Timeout: constant negative input, capture forced on strobe 4095.
    for (int k = 0; k < 4095; k++) strobe(NEG100, 16'h0000);
    check("no_timeout_yet", 32'(bus_if.busy), 32'd0);
    strobe(NEG100, 16'h5500);
    check("timeout_busy", 32'(bus_if.busy), 32'd1);
    check("timeout_forced", 32'(bus_if.forced), 32'd1);
    strobe(NEG100, 16'h0100);
    for (int k = 0; k < 254; k++) strobe(NEG100, 16'h0000);
    check("timeout_done", 32'(bus_if.busy), 32'd0);
    check("forced_held", 32'(bus_if.forced), 32'd1);
    idle_swap("swap_1_to_0", 1'b0);
    read_chk("to_ch0_a0", 3'd0, 8'd0, 8'h7F);
    read_chk("to_ch1_a0", 3'd1, 8'd0, 8'hD5);
    read_chk("to_ch1_a1", 3'd1, 8'd1, 8'h81);

    // Decimation by 4: accepted strobes 3, 7, ..., 1023.
    strobe(NEG100, 16'h0000);
    bus_if.decim = 4'd3;
    for (int k = 0; k < 1023; k++) strobe(16'h0100, 16'(k * 64));
    check("decim_busy", 32'(bus_if.busy), 32'd1);
    check("decim_forced_clr", 32'(bus_if.forced), 32'd0);
    strobe(16'h0100, 16'(1023 * 64));
    check("decim_done", 32'(bus_if.busy), 32'd0);
    bus_if.decim = 4'd0;
    idle_swap("swap_0_to_1b", 1'b1);
    read_chk("dec_ch1_a0", 3'd1, 8'd0, 8'h80);
    read_chk("dec_ch1_a10", 3'd1, 8'd10, 8'h8A);
    read_chk("dec_ch1_a255", 3'd1, 8'd255, 8'h7F);
    read_chk("dec_ch0_a0", 3'd0, 8'd0, 8'h81);

    // Reset in the middle of a capture, then a fresh capture from address 0.
    strobe(NEG100, 16'h0000);
    for (int k = 0; k < 100; k++) strobe(16'h0000, 16'h2200);
    check("mid_capture_busy", 32'(bus_if.busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check("mid_rst_forced", 32'(bus_if.forced), 32'd0);
    check("mid_rst_read_index", 32'(bus_if.read_index), 32'd0);
    check("mid_rst_rd_data", 32'(bus_if.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    strobe(NEG100, 16'h0000);
    check("post_rst_armed", 32'(bus_if.busy), 32'd0);
    strobe(16'h0000, 16'h6600);
    check("post_rst_busy", 32'(bus_if.busy), 32'd1);
    strobe(16'h0000, 16'h7700);
    for (int k = 0; k < 254; k++) strobe(16'h0000, 16'h0000);
    check("post_rst_done", 32'(bus_if.busy), 32'd0);
    idle_swap("swap_after_rst", 1'b1);
    read_chk("restart_a0", 3'd1, 8'd0, 8'hE6);
    read_chk("restart_a1", 3'd1, 8'd1, 8'hF7);
    read_chk("restart_a100", 3'd1, 8'd100, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
